// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_arb_pkg;

  localparam int MULT_ARB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } mult_arb_state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: when both are valid, the
// requester not served last wins. Grant is one-hot (or zero if none valid).
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared repeated-addition
// multiplier. Optional MULT_ARB_ZERO_BYPASS_EN skips the multiplier for zero operands.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = MULT_ARB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  input  logic             rsp1_ready,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_in1,
  output logic [WIDTH-1:0] mul_in2,
  input  logic [WIDTH-1:0] mul_product,
  input  logic             mul_done,
  output logic             busy
);

  mult_arb_state_t  r_state;
  mult_arb_state_t  w_state_next;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_done_prev;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [WIDTH-1:0] r_result;

  logic [1:0]       w_grant;
  logic [1:0]       w_ready;
  logic             w_accept;
  logic             w_zero;
  logic             w_done_edge;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Ready is forced low during reset so nothing can be accepted mid-reset.
  assign w_ready     = (r_state == IDLE && !rst) ? w_grant : 2'b00;
  assign w_accept    = |w_ready;
  assign w_sel_a     = w_grant[1] ? req1_a : req0_a;
  assign w_sel_b     = w_grant[1] ? req1_b : req0_b;
  assign w_done_edge = mul_done & ~r_done_prev;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign w_zero = (w_sel_a == '0) || (w_sel_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = w_zero ? RESP : LAUNCH;
      LAUNCH:  w_state_next = WAIT;
      WAIT:    if (w_done_edge) w_state_next = RESP;
      RESP:    if (r_owner ? rsp1_ready : rsp0_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_done_prev  <= 1'b0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_result     <= '0;
    end else begin
      r_done_prev <= mul_done;
      if (w_accept) begin
        r_in1        <= w_sel_a;
        r_in2        <= w_sel_b;
        r_owner      <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_result     <= '0;
      end else if (r_state == WAIT && w_done_edge) begin
        r_result <= mul_product;
      end
    end
  end

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign mul_start  = (r_state == LAUNCH);
  assign mul_in1    = r_in1;
  assign mul_in2    = r_in2;
  assign busy       = (r_state != IDLE);
  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) && r_owner;
  assign rsp0_data  = rsp0_valid ? r_result : '0;
  assign rsp1_data  = rsp1_valid ? r_result : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter; the multiplier is played
// by the stimulus itself (start observed, done/product driven by hand).
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_ready, rsp1_ready;
  logic       mul_start;
  logic [7:0] mul_in1, mul_in2, mul_product;
  logic       mul_done;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rv(input int w);
    return (w == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [7:0] rd(input int w);
    return (w == 0) ? rsp0_data : rsp1_data;
  endfunction

  task automatic set_req(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (w == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic set_rsp(input int w, input logic v);
    if (w == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  // One full transaction for requester w, which the caller expects to win the pick.
  // stale: WAIT cycles during which an old done stays high; bp: response backpressure cycles.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input int lat, input int stale, input int bp);
    int o = 1 - w;
    bit byp = 1'b0;
    logic [7:0] got;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    byp = (a == 8'd0) || (b == 8'd0);
`endif
    set_req(w, 1'b1, a, b);
    #1;
    check("pick_ready", rdy(w), 1);
    check("other_ready_idle", rdy(o), 0);
    @(negedge clk);
    set_req(w, 1'b0, a, b);
    if (byp) begin
      check("bypass_valid", rv(w), 1);
      check("bypass_no_start", mul_start, 0);
    end else begin
      check("start_high", mul_start, 1);
      check("mul_in1", mul_in1, a);
      check("mul_in2", mul_in2, b);
      if (stale == 0) mul_done = 1'b0;
      for (int i = 0; i < stale; i++) begin
        @(negedge clk);
        check("stale_done_ignored", rv(w), 0);
        check("start_low", mul_start, 0);
      end
      mul_done    = 1'b0;
      mul_product = 8'hEE;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check("wait_no_rsp", rv(w), 0);
        check("start_low", mul_start, 0);
      end
      mul_done    = 1'b1;
      mul_product = exp;
      @(negedge clk);
      check("rsp_valid", rv(w), 1);
    end
    got = rd(w);
    check("rsp_data", got, exp);
    check("other_rsp_valid", rv(o), 0);
    check("other_rsp_data", rd(o), 0);
    check("other_ready_resp", rdy(o), 0);
    check("busy_resp", busy, 1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", rv(w), 1);
      check("bp_data", rd(w), exp);
      check("bp_busy", busy, 1);
      check("bp_no_accept", rdy(o), 0);
    end
    set_rsp(w, 1'b1);
    @(negedge clk);
    set_rsp(w, 1'b0);
    check("idle_busy", busy, 0);
    check("rsp_dropped", rv(w), 0);
    $display("txn req%0d %0d*%0d -> %0d (expected %0d)", w, a, b, got, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    mul_product = 8'd0; mul_done = 1'b0;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", mul_start, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_in1", mul_in1, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single request, done seven cycles after start
    do_op(0, 8'd6, 8'd7, 8'd42, 7, 0, 0);

    // Simultaneous requests after reset, then round-robin alternation
    pulse_reset();
    set_req(1, 1'b1, 8'd5, 8'd5);
    do_op(0, 8'd3, 8'd4, 8'd12, 3, 0, 0);
    set_req(0, 1'b1, 8'd3, 8'd4);
    do_op(1, 8'd5, 8'd5, 8'd25, 3, 0, 0);
    do_op(0, 8'd3, 8'd4, 8'd12, 3, 0, 0);

    // Overflow: 400 mod 256
    do_op(1, 8'd20, 8'd20, 8'd144, 4, 0, 0);

    // Backpressure with req1 pending, then stale done into req1's operation
    set_req(1, 1'b1, 8'd13, 8'd3);
    do_op(0, 8'd9, 8'd11, 8'd99, 2, 0, 5);
    do_op(1, 8'd13, 8'd3, 8'd39, 2, 3, 0);

    // Zero operand
    do_op(0, 8'd0, 8'd9, 8'd0, 2, 0, 0);

    // Reset in the middle of WAIT; last grant was req0, so reset must restore req0 priority
    set_req(0, 1'b1, 8'd2, 8'd3);
    @(negedge clk);
    set_req(0, 1'b0, 8'd2, 8'd3);
    mul_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_start", mul_start, 0);
    check("midrst_in1", mul_in1, 0);
    check("midrst_in2", mul_in2, 0);
    check("midrst_rsp0_valid", rsp0_valid, 0);
    set_req(0, 1'b1, 8'd2, 8'd3);
    set_req(1, 1'b1, 8'd4, 8'd4);
    #1;
    check("midrst_req0_ready", req0_ready, 0);
    check("midrst_req1_ready", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_req0_wins", req0_ready, 1);
    check("postrst_req1_waits", req1_ready, 0);
    set_req(0, 1'b0, 8'd2, 8'd3);
    set_req(1, 1'b0, 8'd4, 8'd4);
    @(negedge clk);
    mul_done = 1'b1;
    mul_product = 8'd6;
    @(negedge clk);
    check("dropped_rsp0", rsp0_valid, 0);
    check("dropped_rsp1", rsp1_valid, 0);
    check("dropped_busy", busy, 0);
    do_op(0, 8'd2, 8'd3, 8'd6, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
